// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter: grants one completed FU result per cycle
// and broadcasts the granted tag/value on the following cycle.
module cdb_arbiter #(
    parameter int NUM_FU = 6,
    parameter int TAG_W  = 5,
    parameter int XLEN   = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       squash,
    input  logic [NUM_FU:1]            fu_valid,
    input  logic [NUM_FU:1][TAG_W-1:0] fu_tag,
    input  logic [NUM_FU:1][XLEN-1:0]  fu_value,
    output logic [NUM_FU:1]            ack,
    output logic                       cdb_valid,
    output logic [TAG_W-1:0]           cdb_tag,
    output logic [XLEN-1:0]            cdb_value,
    output logic [15:0]                cdb_count
);
    localparam int PW = $clog2(NUM_FU + 1);

    logic [PW-1:0] ptr;
    logic [PW-1:0] grant;
    logic [PW-1:0] idx;
    logic [PW-1:0] ptr_next;
    logic          any_grant;

    // Scan ptr..NUM_FU first, then 1..ptr-1, so the search wraps around.
    always_comb begin
        ack       = '0;
        grant     = '0;
        idx       = '0;
        any_grant = 1'b0;
        if (!reset && !squash) begin
            for (int i = 1; i <= NUM_FU; i++) begin
                idx = PW'(i);
                if (!any_grant && fu_valid[idx] && (idx >= ptr)) begin
                    any_grant = 1'b1;
                    grant     = idx;
                end
            end
            for (int i = 1; i <= NUM_FU; i++) begin
                idx = PW'(i);
                if (!any_grant && fu_valid[idx] && (idx < ptr)) begin
                    any_grant = 1'b1;
                    grant     = idx;
                end
            end
        end
        if (any_grant) begin
            ack[grant] = 1'b1;
        end
    end

    assign ptr_next = (grant == PW'(NUM_FU)) ? PW'(1) : grant + PW'(1);

    // Tag and value deliberately hold across idle and squash cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr       <= PW'(1);
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_value <= '0;
            cdb_count <= '0;
        end else if (squash) begin
            ptr       <= PW'(1);
            cdb_valid <= 1'b0;
        end else if (any_grant) begin
            ptr       <= ptr_next;
            cdb_valid <= 1'b1;
            cdb_tag   <= fu_tag[grant];
            cdb_value <= fu_value[grant];
            if (cdb_count != 16'hFFFF) begin
                cdb_count <= cdb_count + 16'd1;
            end
        end else begin
            cdb_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized
// traffic, compared against a round-robin reference model.
`timescale 1ns/1ps
module tb_cdb_arbiter;
    logic             clock;
    logic             reset;
    logic             squash;
    logic [6:1]       fu_valid;
    logic [6:1][4:0]  fu_tag;
    logic [6:1][31:0] fu_value;
    logic [6:1]       ack;
    logic             cdb_valid;
    logic [4:0]       cdb_tag;
    logic [31:0]      cdb_value;
    logic [15:0]      cdb_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_ptr   = 1;
    logic        m_valid = 1'b0;
    logic [4:0]  m_tag   = '0;
    logic [31:0] m_value = '0;
    int          m_count = 0;

    cdb_arbiter #(.NUM_FU(6), .TAG_W(5), .XLEN(32)) dut (
        .clock(clock), .reset(reset), .squash(squash),
        .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_value(fu_value),
        .ack(ack), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_value(cdb_value), .cdb_count(cdb_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [6:1] v, input logic sq);
        fu_valid = v;
        squash   = sq;
        for (int i = 1; i <= 6; i++) begin
            fu_tag[i]   = 5'($urandom);
            fu_value[i] = $urandom;
        end
    endtask

    // Called just after a rising edge (or mid-cycle); checks ack, then the edge.
    task automatic check_output(output int g_obs);
        int         g;
        int         k_idx;
        logic [6:1] exp_ack;
        logic [4:0] g_tag;
        logic [31:0] g_val;
        #2;
        g = 0;
        if (!squash) begin
            for (int k = 0; k < 6; k++) begin
                k_idx = ((m_ptr - 1 + k) % 6) + 1;
                if (g == 0 && fu_valid[k_idx]) g = k_idx;
            end
        end
        exp_ack = '0;
        g_tag   = '0;
        g_val   = '0;
        if (g != 0) begin
            exp_ack[g] = 1'b1;
            g_tag      = fu_tag[g];
            g_val      = fu_value[g];
        end
        check_eq("ack", 32'(ack), 32'(exp_ack));
        g_obs = 0;
        for (int i = 1; i <= 6; i++) if (ack[i]) g_obs = i;
        @(posedge clock);
        #1;
        if (squash) begin
            m_ptr   = 1;
            m_valid = 1'b0;
        end else if (g != 0) begin
            m_ptr   = (g % 6) + 1;
            m_valid = 1'b1;
            m_tag   = g_tag;
            m_value = g_val;
            if (m_count < 65535) m_count++;
        end else begin
            m_valid = 1'b0;
        end
        check_eq("cdb_valid", 32'(cdb_valid), 32'(m_valid));
        check_eq("cdb_tag",   32'(cdb_tag),   32'(m_tag));
        check_eq("cdb_value", cdb_value,      m_value);
        check_eq("cdb_count", 32'(cdb_count), 32'(m_count));
    endtask

    // From just after an edge: assert reset between edges, check, release mid-cycle.
    task automatic pulse_reset();
        #2;
        reset = 1'b1;
        #1;
        check_eq("rst_cdb_valid", 32'(cdb_valid), 32'd0);
        check_eq("rst_cdb_count", 32'(cdb_count), 32'd0);
        check_eq("rst_ack",       32'(ack),       32'd0);
        m_ptr = 1; m_valid = 1'b0; m_tag = '0; m_value = '0; m_count = 0;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        int         g;
        logic [6:1] pending;
        logic       sq;

        reset = 1'b0;
        squash = 1'b0;
        fu_valid = '1;
        fu_tag = '0;
        fu_value = '0;
        #1 reset = 1'b1;
        #2;
        check_eq("reset_ack",   32'(ack),       32'd0);
        check_eq("reset_valid", 32'(cdb_valid), 32'd0);
        check_eq("reset_tag",   32'(cdb_tag),   32'd0);
        check_eq("reset_value", cdb_value,      32'd0);
        check_eq("reset_count", 32'(cdb_count), 32'd0);
        @(posedge clock);
        #1;
        check_eq("reset_edge_ack",   32'(ack),       32'd0);
        check_eq("reset_edge_valid", 32'(cdb_valid), 32'd0);
        reset = 1'b0;

        // Single request on FU 5
        apply_stimulus(6'b010000, 1'b0);
        fu_tag[5] = 5'd3;
        fu_value[5] = 32'hDEAD_BEEF;
        check_output(g);
        check_eq("single_grant", 32'(g), 32'd5);
        check_eq("single_tag",   32'(cdb_tag),   32'd3);
        check_eq("single_value", cdb_value,      32'hDEAD_BEEF);
        check_eq("single_count", 32'(cdb_count), 32'd1);

        // Wrap-around from ptr=6 with requests on 2 and 6
        apply_stimulus(6'b100010, 1'b0);
        check_output(g);
        check_eq("wrap_first", 32'(g), 32'd6);
        apply_stimulus(6'b000010, 1'b0);
        check_output(g);
        check_eq("wrap_second", 32'(g), 32'd2);
        apply_stimulus(6'b000101, 1'b0);
        check_output(g);
        check_eq("wrap_ptr3", 32'(g), 32'd3);

        // Squash with a broadcast already registered
        check_eq("pre_squash_valid", 32'(cdb_valid), 32'd1);
        apply_stimulus(6'b000011, 1'b1);
        #1;
        check_eq("squash_bcast_visible", 32'(cdb_valid), 32'd1);
        check_output(g);
        check_eq("squash_no_grant", 32'(g), 32'd0);
        apply_stimulus(6'b010010, 1'b0);
        check_output(g);
        check_eq("squash_ptr1", 32'(g), 32'd2);
        apply_stimulus(6'b000000, 1'b1);
        check_output(g);

        // Round-robin fairness from ptr=1
        pending = '1;
        for (int k = 1; k <= 6; k++) begin
            apply_stimulus(pending, 1'b0);
            check_output(g);
            check_eq("rr_order", 32'(g), 32'(k));
            check_eq("rr_bcast", 32'(cdb_valid), 32'd1);
            if (g >= 1 && g <= 6) pending[g] = 1'b0;
        end
        apply_stimulus('1, 1'b0);
        check_output(g);
        check_eq("rr_wrap", 32'(g), 32'd1);

        // Randomized traffic with drops and occasional squash
        pending = 6'($urandom);
        for (int c = 0; c < 300; c++) begin
            sq = ($urandom_range(0, 7) == 0);
            apply_stimulus(pending, sq);
            check_output(g);
            if (g >= 1 && g <= 6) pending[g] = 1'b0;
            for (int i = 1; i <= 6; i++) begin
                if (pending[i] && $urandom_range(0, 19) == 0) pending[i] = 1'b0;
                else if (!pending[i] && $urandom_range(0, 2) == 0) pending[i] = 1'b1;
            end
        end

        // Asynchronous reset while a broadcast is live and count is 7
        pulse_reset();
        for (int k = 0; k < 7; k++) begin
            apply_stimulus('1, 1'b0);
            check_output(g);
        end
        check_eq("async_pre_valid", 32'(cdb_valid), 32'd1);
        check_eq("async_pre_count", 32'(cdb_count), 32'd7);
        pulse_reset();
        apply_stimulus('1, 1'b0);
        check_output(g);
        check_eq("post_reset_grant", 32'(g), 32'd1);

        // Counter saturation
        pulse_reset();
        for (int k = 0; k < 65535; k++) begin
            apply_stimulus('1, 1'b0);
            check_output(g);
        end
        check_eq("sat_reach", 32'(cdb_count), 32'hFFFF);
        apply_stimulus('1, 1'b0);
        check_output(g);
        check_eq("sat_hold", 32'(cdb_count), 32'hFFFF);
        check_eq("sat_valid", 32'(cdb_valid), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_FU, default 6, meaning the number of functional-unit request slots, indexed 1..NUM_FU.
REQ-002 The block SHALL have parameter TAG_W, default 5, meaning the ROB tag width.
REQ-003 The block SHALL have parameter XLEN, default 32, meaning the result data width.
REQ-004 Port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port squash, input, 1: pipeline flush.
REQ-007 Port fu_valid, input, NUM_FU (indices 1..NUM_FU): FU i holds a completed result.
REQ-008 Port fu_tag, input, NUM_FU x TAG_W: ROB tag of each FU result.
REQ-009 Port fu_value, input, NUM_FU x XLEN: result value of each FU.
REQ-010 Port ack, output, NUM_FU (indices 1..NUM_FU): grant to FU i; FU i releases its result after the edge where ack[i]=1.
REQ-011 Port cdb_valid, output, 1: a broadcast is valid this cycle.
REQ-012 Port cdb_tag, output, TAG_W: broadcast ROB tag.
REQ-013 Port cdb_value, output, XLEN: broadcast value.
REQ-014 Port cdb_count, output, 16: count of broadcasts since reset, for debug.

Function
REQ-015 ack SHALL be combinational from fu_valid, squash and the priority pointer.
REQ-016 At most one ack bit SHALL be high in any cycle.
REQ-017 ack[i] SHALL be high only when fu_valid[i]=1 and squash=0.
REQ-018 When squash=0 and any fu_valid bit is set, exactly one ack bit SHALL be high (work-conserving).
REQ-019 The grant SHALL be round-robin: the first requesting index found scanning ptr, ptr+1, ..., NUM_FU, 1, ..., ptr-1.
REQ-020 The pointer ptr SHALL range over 1..NUM_FU.
REQ-021 On a grant to index g, ptr SHALL become g+1 at the next edge, wrapping to 1 when g=NUM_FU.
REQ-022 With no grant, ptr SHALL hold.
REQ-023 The broadcast SHALL have 1-cycle latency: on the edge ending a grant cycle for g, cdb_valid<=1, cdb_tag<=fu_tag[g], cdb_value<=fu_value[g].
REQ-024 On an edge ending a cycle with no grant, cdb_valid<=0; cdb_tag and cdb_value SHALL hold their previous values.
REQ-025 squash=1 SHALL suppress all ack in that cycle.
REQ-026 On the edge ending a squash cycle: cdb_valid<=0, ptr<=1, and cdb_count holds.
REQ-027 A broadcast already registered before the squash edge SHALL still be visible for its one cycle.
REQ-028 cdb_count SHALL increment by 1 on every edge that loads cdb_valid<=1.
REQ-029 cdb_count SHALL saturate at 16'hFFFF.
REQ-030 A FU whose fu_valid drops without an ack SHALL be dropped silently, with no state change.
REQ-031 Bits of fu_tag and fu_value for non-granted FUs SHALL NOT affect any output.

Reset
REQ-032 While reset=1, asynchronously and independent of clock: ptr=1, cdb_valid=0, cdb_tag=0, cdb_value=0, cdb_count=0.
REQ-033 While reset=1, ack SHALL be all zero.
REQ-034 Reset asserted mid-operation SHALL discard any pending grant.
REQ-035 The first edge after reset deasserts SHALL arbitrate normally from ptr=1.

Verification
REQ-036 Single request: after reset, fu_valid[5]=1, tag=3, value=32'hDEAD_BEEF for one cycle -> ack[5]=1 that cycle; next cycle cdb_valid=1, cdb_tag=3, cdb_value=DEADBEEF, cdb_count=1.
REQ-037 Round-robin fairness: all six fu_valid held high, each FU dropping valid one cycle after its ack -> grant order 1,2,3,4,5,6; six consecutive cdb_valid cycles; ptr wraps to 1.
REQ-038 Wrap-around: ptr=6 (after a grant to 5), requests on 2 and 6 -> grant 6 first, then 2; ptr=3 afterwards.
REQ-039 Squash: requests on 1 and 2 with squash=1 in cycle N -> no ack in N; cdb_valid=0 in N+1; ptr=1; a broadcast registered at edge N-1 remains visible in cycle N.
REQ-040 Async reset: assert reset between clock edges while cdb_valid=1 and cdb_count=7 -> cdb_valid and cdb_count go to 0 immediately, without waiting for an edge.
REQ-041 Saturation: force 65535 broadcasts -> cdb_count stays 16'hFFFF on the next broadcast.
